// File: rtl/seq_detector_param_if.sv
// Serial-stream bus for seq_detector_param: stream, pattern load, count clear and results.
// The master side drives the stream and control; the slave side is the detector.
interface seq_detector_param_if #(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned LEN_W = $clog2(PAT_W + 1)
);
    logic             in_valid;
    logic             in_bit;
    logic             overlap;
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
    logic [LEN_W-1:0] pat_len;
    logic             clear_count;
    logic             detected;
    logic [CNT_W-1:0] match_count;
    logic             seen;

    modport master (
        output in_valid, in_bit, overlap, pat_load, pat_in, pat_len, clear_count,
        input  detected, match_count, seen
    );

    modport slave (
        input  in_valid, in_bit, overlap, pat_load, pat_in, pat_len, clear_count,
        output detected, match_count, seen
    );
endinterface

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial bit-pattern detector with overlapping/non-overlapping
// match modes and a saturating match counter.
// Optional macro SEQ_DET_STICKY_EN: when defined, 'seen' is a sticky match flag;
// otherwise 'seen' is tied to 0 and no register is built.
module seq_detector_param #(
    parameter int unsigned       PAT_W       = 8,
    parameter logic [PAT_W-1:0]  DEFAULT_PAT = 8'b1011_0110,
    parameter int unsigned       CNT_W       = 8,
    parameter int unsigned       LEN_W       = $clog2(PAT_W + 1)
) (
    input logic                clk,
    input logic                rst,
    seq_detector_param_if.slave bus
);
    localparam logic [LEN_W-1:0] PatWL  = LEN_W'(PAT_W);
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic [PAT_W-1:0] hist_q, hist_d, pat_q, pat_d;
    logic [LEN_W-1:0] fill_q, fill_d, len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             det_q, det_d;

    logic [PAT_W-1:0] hist_n;
    logic [LEN_W-1:0] fill_n;
    logic [PAT_W-1:0] len_mask;
    logic             match;

    // Candidate shift/fill for an accepted bit and the masked pattern compare
    always_comb begin
        hist_n   = {hist_q[PAT_W-2:0], bus.in_bit};
        fill_n   = (fill_q >= PatWL) ? PatWL : fill_q + LEN_W'(1);
        len_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
        match = bus.in_valid && !bus.pat_load && (fill_n >= len_q) &&
                (((hist_n ^ pat_q) & len_mask) == '0);
    end

    // Next-state for pattern registers, history, pulse and counter
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        len_d  = len_q;
        det_d  = 1'b0;
        cnt_d  = cnt_q;

        if (bus.pat_load) begin
            pat_d  = bus.pat_in;
            // Zero or oversized lengths fall back to the full register width
            len_d  = (bus.pat_len == '0 || bus.pat_len > PatWL) ? PatWL : bus.pat_len;
            hist_d = '0;
            fill_d = '0;
        end else if (bus.in_valid) begin
            det_d = match;
            if (match && !bus.overlap) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = hist_n;
                fill_d = fill_n;
            end
        end

        // A match coinciding with a clear counts as the first match after it
        if (match) begin
            if (bus.clear_count) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != CntMax) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (bus.clear_count) begin
            cnt_d = '0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= DEFAULT_PAT;
            len_q  <= PatWL;
            det_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            len_q  <= len_d;
            det_q  <= det_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.detected    = det_q;
    assign bus.match_count = cnt_q;

`ifdef SEQ_DET_STICKY_EN
    logic seen_q;

    // Sticky flag: set on any match, cleared by reset or clear_count (match wins)
    always_ff @(posedge clk) begin
        if (rst) begin
            seen_q <= 1'b0;
        end else if (match) begin
            seen_q <= 1'b1;
        end else if (bus.clear_count) begin
            seen_q <= 1'b0;
        end
    end

    assign bus.seen = seen_q;
`else
    assign bus.seen = 1'b0;
`endif

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Runtime-programmable serial bit-pattern detector; successor to the fixed 8-state sequence detector.
- Pattern value and length are loadable; supports overlapping and non-overlapping match modes; tracks a saturating match count.
- Sits on a qualified single-bit serial stream (`in_valid`/`in_bit`) and produces a one-cycle `detected` pulse per match.

Parameters:
- PAT_W, 8: maximum pattern length in bits (>= 2).
- DEFAULT_PAT, 8'b1011_0110: pattern loaded at reset; width PAT_W.
- CNT_W, 8: match counter width (>= 1).
- LEN_W, $clog2(PAT_W+1): width of the pattern-length field; derived, do not override.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  in_bit is consumed on this edge when high.
- in_bit  in  1  serial data bit.
- overlap  in  1  1 = overlapping matches, 0 = non-overlapping.
- pat_load  in  1  load pat_in/pat_len this edge.
- pat_in  in  PAT_W  new pattern; low pat_len bits used, MSB of that field received first.
- pat_len  in  LEN_W  new pattern length.
- clear_count  in  1  synchronous clear of match_count (and seen).
- detected  out  1  registered one-cycle match pulse.
- match_count  out  CNT_W  saturating number of matches.
- seen  out  1  sticky match flag (see Optional Feature).

Behaviour:
- Clocking/reset: one clock `clk`; reset `rst` is synchronous and active-high. On an `rst` edge:
  - pat_reg = DEFAULT_PAT, len_reg = PAT_W.
  - hist = 0, fill = 0.
  - detected = 0, match_count = 0, seen = 0.
  - rst overrides every other input.
- State:
  - hist[PAT_W-1:0] shift register, newest bit in bit 0.
  - fill = bits accepted since the last restart, saturating at PAT_W.
  - pat_reg, len_reg.
- pat_load (priority over in_valid):
  - pat_reg <= pat_in.
  - len_reg <= pat_len; if pat_len is 0 or greater than PAT_W, len_reg <= PAT_W.
  - hist <= 0, fill <= 0.
  - in_valid in the same cycle is ignored; detected <= 0.
  - match_count is unaffected.
- in_valid=1 without pat_load:
  - Update: hist_n = {hist[PAT_W-2:0], in_bit}; fill_n = min(fill+1, PAT_W).
  - Match when fill_n >= len_reg and the low len_reg bits of hist_n equal the low len_reg bits of pat_reg.
  - detected <= match.
  - On match with overlap=0: fill <= 0 and hist <= 0. On match with overlap=1: fill <= fill_n and hist <= hist_n.
  - No match: hist <= hist_n, fill <= fill_n.
- in_valid=0: hist and fill hold; detected <= 0.
- Latency: detected goes high in the cycle after the edge that accepted the completing bit, for exactly one cycle.
  - Back-to-back matches (e.g. pattern 11, stream 111 with overlap=1) give consecutive detected cycles.
- overlap is sampled on each accepting edge, so changing it mid-stream takes effect on the next match.
- match_count:
  - Increments on the same edge detected is set.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - clear_count alone gives 0.
  - clear_count coincident with a match gives 1.
- Reset mid-pattern discards all partial history; a pattern straddling reset is never detected.

Optional Feature:
- Macro: SEQ_DET_STICKY_EN.
- Defined:
  - seen is set on the edge of any match and stays 1.
  - seen is cleared by rst or clear_count; if clear_count coincides with a match, seen = 1.
- Undefined: seen is tied to constant 0 and no register is generated. Port list is identical in both builds.

Test Plan:
- Reset defaults, stream B6 MSB-first (1,0,1,1,0,1,1,0) with in_valid=1 -> detected=1 only in the cycle after bit 8; match_count=1.
- Load pat_in=8'h0B, pat_len=4 (pattern 1011), overlap=1, stream 1011011 -> detected after bits 4 and 7; match_count=2.
- Same load, overlap=0, stream 1011011 -> detected only after bit 4; match_count=1.
- Pattern 1011, stream 1,0,1,1 with in_valid=0 gaps of 2 cycles between bits -> single detected after bit 4; also pat_len=0 load -> len_reg=8 and a 4-bit stream never matches.
- CNT_W=2, pattern 11, overlap=1, stream six 1s -> five detected pulses, match_count saturates at 3; then clear_count asserted on the edge of a match -> match_count=1, seen=1 if SEQ_DET_STICKY_EN else 0.
- Pattern 1011, stream 1,0,1, rst for 1 cycle, then 1 -> no detected; match_count=0; pat_reg back to DEFAULT_PAT.
